instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: the first fetch address after reset.
REQ-002 SHALL have port clock, input, 1 bit: all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-004 SHALL have port stall, input, 1 bit: the downstream IF/ID buffer must hold its contents.
REQ-005 SHALL have port branch_enable, input, 1 bit: redirect request from decode.
REQ-006 SHALL have port branch_target, input, 32 bits: redirect address; bits [1:0] are ignored.
REQ-007 SHALL have port imem_request, output, 1 bit: instruction memory read request.
REQ-008 SHALL have port imem_address, output, 32 bits: word-aligned fetch address, bits [1:0] always 00.
REQ-009 SHALL have port imem_ready, input, 1 bit: imem_data is valid in this cycle.
REQ-010 SHALL have port imem_data, input, 32 bits: fetched instruction word.
REQ-011 SHALL have port if_program_counter, output, 32 bits: registered PC of the presented instruction.
REQ-012 SHALL have port if_instruction, output, 32 bits: registered instruction; 0 (NOP) when invalid.
REQ-013 SHALL have port if_valid, output, 1 bit: if_instruction holds a real fetched instruction.

Function
REQ-014 SHALL implement the states FETCH and HOLD; FETCH drives imem_request=1 and imem_address=pc; HOLD drives imem_request=0.
REQ-015 SHALL, in FETCH with stall=0 and imem_ready=1, register if_program_counter<=pc, if_instruction<=imem_data, if_valid<=1 and pc<=pc+4 (one-cycle latency, ready to output).
REQ-016 SHALL, in FETCH with stall=0 and imem_ready=0, register if_valid<=0 and if_instruction<=0 (bubble), with pc unchanged.
REQ-017 SHALL, in FETCH with stall=1 and imem_ready=1, capture pc and imem_data into a one-entry skid register, set pc<=pc+4 and go to HOLD; all outputs stay unchanged.
REQ-018 SHALL hold all if_* outputs unchanged in every cycle with stall=1, in any state.
REQ-019 SHALL, in HOLD with stall=0, move the skid contents to the if_* outputs with if_valid=1 and return to FETCH.
REQ-020 SHALL sample branch_enable only when stall=0, and SHALL ignore it when stall=1.
REQ-021 SHALL wrap the PC modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0000_0000).
REQ-022 SHALL keep imem_address stable while imem_request=1 and imem_ready=0, except on a redirect allowed by REQ-023/REQ-027.
REQ-023 SHALL, without the delay-slot feature, on an accepted branch: set pc<={branch_target[31:2],2'b00}; discard any imem_data returned in the same cycle and any skid entry; register if_valid<=0 and if_instruction<=0; and go to FETCH.

Reset
REQ-024 SHALL, on reset, set pc=RESET_VECTOR, state=FETCH, if_program_counter=0, if_instruction=0, if_valid=0, the skid register empty and the pending branch cleared.
REQ-025 SHALL drive imem_request=0 in any cycle in which reset=1, and SHALL issue the first request in the first cycle after reset deasserts.
REQ-026 SHALL let reset override stall, branch_enable and imem_ready, in any state.

Configuration
REQ-027 SHALL, with macro INSTRUCTION_FETCH_DELAY_SLOT_EN defined, on an accepted branch:
- deliver the instruction returned in that cycle, or the skid entry, normally as the delay slot;
- set the next pc to the branch target instead of pc+4;
- if no response arrives in that cycle, record the target in a pending-branch register and apply it after the next delivered fetch.
REQ-028 SHALL behave exactly per REQ-023 when INSTRUCTION_FETCH_DELAY_SLOT_EN is undefined, with no pending-branch register synthesized.

Verification
REQ-029 SHALL cover: reset, then imem_ready=1 constantly -> imem_address 0,4,8; if_program_counter 0,4,8 each one cycle later; if_valid=1.
REQ-030 SHALL cover: stall=1 in the cycle the word at 0x8 returns, held 3 cycles -> outputs frozen at PC 0x4; imem_request=0; after release, PC 0x8 is presented, then the fetch of 0xC.
REQ-031 SHALL cover: no delay-slot build, branch_enable with target 0x100 while fetching 0x10 -> 0x10 discarded, one bubble (if_valid=0), next imem_address=0x100.
REQ-032 SHALL cover: delay-slot build, same stimulus -> 0x10 delivered, next imem_address=0x100; also with imem_ready=0 in the branch cycle -> 0x10 delivered later, then 0x100.
REQ-033 SHALL cover: RESET_VECTOR=32'hFFFF_FFF8 with continuous ready -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 SHALL cover: reset asserted in HOLD -> next cycle if_valid=0, skid empty, imem_request=0, pc=RESET_VECTOR.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch -- single-issue instruction fetch stage with a one-entry
// skid register between the instruction memory and the IF/ID buffer.
//
// Parameters:
//   RESET_VECTOR        first fetch address after reset (word aligned)
// Ports:
//   clock               rising-edge clock
//   reset               synchronous, active-high; overrides all other inputs
//   stall               IF/ID buffer must hold; if_* outputs freeze
//   branch_enable       redirect request from decode (ignored while stalled)
//   branch_target       redirect address, bits [1:0] ignored
//   imem_request        instruction memory read request (FETCH state only)
//   imem_address        word-aligned fetch address (the current pc)
//   imem_ready          imem_data valid this cycle
//   imem_data           fetched instruction word
//   if_program_counter  registered pc of the presented instruction
//   if_instruction      registered instruction, 0 (NOP) when not valid
//   if_valid            if_instruction holds a real fetched instruction
// Build option:
//   INSTRUCTION_FETCH_DELAY_SLOT_EN  branch delay slot: the word fetched in
//   the branch cycle (or the skid entry) is delivered, and the target is
//   applied afterwards, via a pending-branch register when no word arrived.
//
// state | meaning
// FETCH | request issued at pc; responses go straight to the if_* outputs
// HOLD  | skid holds a word captured under stall; no request issued
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_enable,
  input  logic [31:0] branch_target,
  output logic        imem_request,
  output logic [31:0] imem_address,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] if_program_counter,
  output logic [31:0] if_instruction,
  output logic        if_valid
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_data;
  logic [31:0] target_aligned;
  logic [31:0] next_seq_pc;
  logic        unused_target_bits;

  assign target_aligned     = {branch_target[31:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];

`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
  logic        pending;
  logic [31:0] pending_target;

  // A branch recorded while waiting for its delay slot replaces pc+4 once
  // that delay-slot word has been taken.
  assign next_seq_pc = pending ? pending_target : pc + 32'd4;
`else
  assign next_seq_pc = pc + 32'd4;
`endif

  // Reset gates the request combinationally so no fetch leaves during reset.
  assign imem_request = (state == FETCH) && !reset;
  assign imem_address = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= FETCH;
      pc                 <= RESET_VECTOR;
      skid_pc            <= 32'd0;
      skid_data          <= 32'd0;
      if_program_counter <= 32'd0;
      if_instruction     <= 32'd0;
      if_valid           <= 1'b0;
`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
      pending            <= 1'b0;
      pending_target     <= 32'd0;
`endif
    end else if (stall) begin
      // Outputs frozen; a word arriving now is parked and fetching pauses.
      if (state == FETCH && imem_ready) begin
        skid_pc   <= pc;
        skid_data <= imem_data;
        pc        <= next_seq_pc;
        state     <= HOLD;
`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
        pending   <= 1'b0;
`endif
      end
    end else if (branch_enable) begin
`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
      if (state == HOLD) begin
        if_program_counter <= skid_pc;
        if_instruction     <= skid_data;
        if_valid           <= 1'b1;
        pc                 <= target_aligned;
        pending            <= 1'b0;
        state              <= FETCH;
      end else if (imem_ready) begin
        if_program_counter <= pc;
        if_instruction     <= imem_data;
        if_valid           <= 1'b1;
        pc                 <= target_aligned;
        pending            <= 1'b0;
      end else begin
        // Delay slot still outstanding: keep fetching pc, remember target.
        if_instruction     <= 32'd0;
        if_valid           <= 1'b0;
        pending            <= 1'b1;
        pending_target     <= target_aligned;
      end
`else
      // Redirect squashes both the in-flight response and the skid entry.
      pc             <= target_aligned;
      if_instruction <= 32'd0;
      if_valid       <= 1'b0;
      state          <= FETCH;
`endif
    end else if (state == HOLD) begin
      if_program_counter <= skid_pc;
      if_instruction     <= skid_data;
      if_valid           <= 1'b1;
      state              <= FETCH;
    end else if (imem_ready) begin
      if_program_counter <= pc;
      if_instruction     <= imem_data;
      if_valid           <= 1'b1;
      pc                 <= next_seq_pc;
`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
      pending            <= 1'b0;
`endif
    end else begin
      if_instruction <= 32'd0;
      if_valid       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. Two instances share stimulus:
// A with the default reset vector, B with 32'hFFFF_FFF8 (wrap-around).
// A transaction-level model predicts every output after every clock edge.
module tb_instruction_fetch;

  localparam logic [31:0] RVA = 32'h0000_0000;
  localparam logic [31:0] RVB = 32'hFFFF_FFF8;
`ifdef INSTRUCTION_FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_enable;
  logic [31:0] branch_target;
  logic        imem_ready;
  logic [31:0] imem_data;

  logic        a_req, b_req, a_valid, b_valid;
  logic [31:0] a_addr, b_addr, a_pc, b_pc, a_ins, b_ins;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  instruction_fetch #(.RESET_VECTOR(RVA)) dut_a (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_enable(branch_enable), .branch_target(branch_target),
    .imem_request(a_req), .imem_address(a_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .if_program_counter(a_pc), .if_instruction(a_ins), .if_valid(a_valid)
  );

  instruction_fetch #(.RESET_VECTOR(RVB)) dut_b (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_enable(branch_enable), .branch_target(branch_target),
    .imem_request(b_req), .imem_address(b_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .if_program_counter(b_pc), .if_instruction(b_ins), .if_valid(b_valid)
  );

  // Model: next address to fetch, an optional parked word, an optional
  // deferred branch target, and the instruction currently presented.
  typedef struct {
    logic [31:0] next_addr;
    bit          parked;
    logic [31:0] park_pc;
    logic [31:0] park_word;
    bit          deferred;
    logic [31:0] defer_to;
    logic [31:0] out_pc;
    logic [31:0] out_word;
    bit          out_real;
  } model_t;

  model_t ma, mb;

  function automatic model_t present(model_t m, logic [31:0] p, logic [31:0] w);
    m.out_pc = p; m.out_word = w; m.out_real = 1'b1;
    return m;
  endfunction

  function automatic model_t bubble(model_t m);
    m.out_word = 32'd0; m.out_real = 1'b0;
    return m;
  endfunction

  function automatic model_t advance(model_t m, logic [31:0] rv, bit r, bit s,
                                     bit b, logic [31:0] t, bit rdy,
                                     logic [31:0] d);
    logic [31:0] tgt, after;
    tgt   = t & 32'hFFFF_FFFC;
    after = m.deferred ? m.defer_to : m.next_addr + 32'd4;
    if (r) begin
      m = '{next_addr: rv, parked: 1'b0, park_pc: 32'd0, park_word: 32'd0,
            deferred: 1'b0, defer_to: 32'd0, out_pc: 32'd0, out_word: 32'd0,
            out_real: 1'b0};
    end else if (s) begin
      if (!m.parked && rdy) begin
        m.parked = 1'b1; m.park_pc = m.next_addr; m.park_word = d;
        m.next_addr = after; m.deferred = 1'b0;
      end
    end else if (b && !DS) begin
      m.next_addr = tgt; m.parked = 1'b0;
      m = bubble(m);
    end else if (b) begin
      if (m.parked) begin
        m = present(m, m.park_pc, m.park_word);
        m.parked = 1'b0; m.next_addr = tgt; m.deferred = 1'b0;
      end else if (rdy) begin
        m = present(m, m.next_addr, d);
        m.next_addr = tgt; m.deferred = 1'b0;
      end else begin
        m = bubble(m);
        m.deferred = 1'b1; m.defer_to = tgt;
      end
    end else if (m.parked) begin
      m = present(m, m.park_pc, m.park_word);
      m.parked = 1'b0;
    end else if (rdy) begin
      m = present(m, m.next_addr, d);
      m.next_addr = after; m.deferred = 1'b0;
    end else begin
      m = bubble(m);
    end
    return m;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a_request", {31'd0, a_req}, {31'd0, !reset && !ma.parked});
    check("a_address", a_addr, ma.next_addr);
    check("a_if_pc",   a_pc,   ma.out_pc);
    check("a_if_ins",  a_ins,  ma.out_word);
    check("a_if_valid", {31'd0, a_valid}, {31'd0, ma.out_real});
    check("b_request", {31'd0, b_req}, {31'd0, !reset && !mb.parked});
    check("b_address", b_addr, mb.next_addr);
    check("b_if_pc",   b_pc,   mb.out_pc);
    check("b_if_ins",  b_ins,  mb.out_word);
    check("b_if_valid", {31'd0, b_valid}, {31'd0, mb.out_real});
  endtask

  task automatic step(bit r, bit s, bit b, logic [31:0] t, bit rdy,
                      logic [31:0] d);
    @(negedge clock);
    reset = r; stall = s; branch_enable = b; branch_target = t;
    imem_ready = rdy; imem_data = d;
    @(posedge clock);
    ma = advance(ma, RVA, r, s, b, t, rdy, d);
    mb = advance(mb, RVB, r, s, b, t, rdy, d);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_enable = 1'b0;
    branch_target = 32'd0; imem_ready = 1'b0; imem_data = 32'd0;

    // Reset, then continuous ready: addresses 0,4,8 and PCs one cycle later.
    step(1, 0, 0, 0, 1, 32'hDEAD_0000);
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_req", {31'd0, a_req}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("first_req", {31'd0, a_req}, 32'd1);
    check("addr0", a_addr, 32'h0);
    check("b_addr0", b_addr, 32'hFFFF_FFF8);
    step(0, 0, 0, 0, 1, 32'h1111_0000);
    check("pc0", a_pc, 32'h0);
    check("addr4", a_addr, 32'h4);
    check("b_addr1", b_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, 32'h1111_0004);
    check("pc4", a_pc, 32'h4);
    check("addr8", a_addr, 32'h8);
    check("b_wrap", b_addr, 32'h0000_0000);
    check("b_pc_wrap", b_pc, 32'hFFFF_FFFC);

    // Stall in the cycle the word at 0x8 returns, held three cycles.
    step(0, 1, 0, 0, 1, 32'h1111_0008);
    check("stall_pc", a_pc, 32'h4);
    check("stall_req", {31'd0, a_req}, 32'd0);
    step(0, 1, 1, 32'h500, 1, 32'hBAD0_0000);
    step(0, 1, 0, 0, 0, 0);
    check("held_pc", a_pc, 32'h4);
    check("held_ins", a_ins, 32'h1111_0004);
    step(0, 0, 0, 0, 0, 0);
    check("rel_pc8", a_pc, 32'h8);
    check("rel_ins", a_ins, 32'h1111_0008);
    check("rel_addrC", a_addr, 32'hC);
    step(0, 0, 0, 0, 1, 32'h1111_000C);
    check("pcC", a_pc, 32'hC);
    check("addr10", a_addr, 32'h10);

    // Branch to 0x100 while the word at 0x10 returns (low bits ignored).
    step(0, 0, 1, 32'h103, 1, 32'h1111_0010);
    check("br_addr", a_addr, 32'h100);
    if (DS) check("ds_pc10", a_pc, 32'h10);
    else    check("nods_bubble", {31'd0, a_valid}, 32'd0);
    step(0, 0, 0, 0, 1, 32'h2222_0100);
    check("tgt_pc", a_pc, 32'h100);
    check("tgt_addr", a_addr, 32'h104);
    // Branch with no response in the branch cycle.
    step(0, 0, 1, 32'h200, 0, 0);
    check("br2_bubble", {31'd0, a_valid}, 32'd0);
    check("br2_addr", a_addr, DS ? 32'h104 : 32'h200);
    step(0, 0, 0, 0, 1, 32'h3333_0000);
    check("br2_pc", a_pc, DS ? 32'h104 : 32'h200);
    check("br2_next", a_addr, DS ? 32'h200 : 32'h204);

    // Reset while holding a parked word.
    step(0, 1, 0, 0, 1, 32'h4444_0000);
    check("hold_req", {31'd0, a_req}, 32'd0);
    step(1, 1, 1, 32'h900, 1, 32'h5555_0000);
    check("hrst_valid", {31'd0, a_valid}, 32'd0);
    check("hrst_req", {31'd0, a_req}, 32'd0);
    check("hrst_addr", b_addr, 32'hFFFF_FFF8);
    step(0, 0, 0, 0, 0, 0);
    check("hrst_fetch", {31'd0, a_req}, 32'd1);
    check("hrst_noskid", {31'd0, a_valid}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 15,
           $urandom,
           $urandom_range(0, 99) < 60,
           $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
